response_builder: RTL and testbench

- Sits directly downstream of the TERO evaluation state machine.
- Captures the shared oscillation counter on each store_response_puf pulse and divides it by REPETITIONS (right shift) to form the per-loop average.
- Stores each average under the loop index given by select_puf.
- When the state machine signals done, compares loop pairs (2k vs 2k+1) to form the PUF response word, then hands it out on a valid/ready port.

---
 rtl/response_builder.sv | 172 +++++++++++++++++
 tb/tb_response_builder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_builder.sv
`default_nettype none
// ============================================================================
// Module   : response_builder
// Brief    : Averages per-loop TERO oscillation counts, compares loop pairs
//            into a PUF response word and offers it on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module response_builder #(
    parameter int NUM_LOOPS     = 4,
    parameter int SEL_BITS      = $clog2(NUM_LOOPS-1)+1,
    parameter int COUNT_BITS    = 32,
    parameter int AVG_SHIFT     = 12,
    parameter int AVG_BITS      = 16,
    parameter int RESPONSE_BITS = NUM_LOOPS/2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     store_response_puf,
    input  logic [SEL_BITS-1:0]      select_puf,
    input  logic [COUNT_BITS-1:0]    counter_value,
    input  logic                     fsm_done,
    output logic [RESPONSE_BITS-1:0] response,
    output logic                     response_valid,
    input  logic                     response_ready,
    output logic                     busy,
    output logic                     error
);

    localparam int c_pair_bits = (RESPONSE_BITS > 1) ? $clog2(RESPONSE_BITS) : 1;
    localparam logic [c_pair_bits-1:0] c_last_pair = c_pair_bits'(RESPONSE_BITS-1);

    typedef enum logic [1:0] {
        S_COLLECT      = 2'd0,
        S_COMPARE      = 2'd1,
        S_OUTPUT       = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [AVG_BITS-1:0]      r_avg [NUM_LOOPS];
    logic [NUM_LOOPS-1:0]     r_captured;
    logic [c_pair_bits-1:0]   r_pair;
    logic [RESPONSE_BITS-1:0] r_response;
    logic                     r_valid;
    logic                     r_error;

    logic [COUNT_BITS-1:0]    w_shifted;
    logic [AVG_BITS-1:0]      w_avg_in;
    logic [NUM_LOOPS-1:0]     w_sel_onehot;
    logic [NUM_LOOPS-1:0]     w_captured_next;
    logic [RESPONSE_BITS-1:0] w_pair_gt;
    logic                     w_in_collect;
    logic                     w_sel_in_range;
    logic                     w_store_ok;
    logic                     w_duplicate;
    logic                     w_incomplete;
    logic                     w_error_set;

    // Averages that do not fit in AVG_BITS saturate instead of wrapping.
    assign w_shifted = counter_value >> AVG_SHIFT;
    assign w_avg_in  = ((w_shifted >> AVG_BITS) != '0) ? '1 : w_shifted[AVG_BITS-1:0];

    generate
        for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_sel
            assign w_sel_onehot[i] = (select_puf == SEL_BITS'(i));
        end
        for (genvar j = 0; j < RESPONSE_BITS; j++) begin : g_pair
            assign w_pair_gt[j] = (r_avg[2*j] > r_avg[2*j+1]);
        end
    endgenerate

    assign w_in_collect    = (r_state == S_COLLECT);
    assign w_sel_in_range  = |w_sel_onehot;
    assign w_store_ok      = w_in_collect & store_response_puf & w_sel_in_range;
    assign w_duplicate     = |(w_sel_onehot & r_captured);
    assign w_captured_next = r_captured | (w_store_ok ? w_sel_onehot : '0);
    assign w_incomplete    = ~&w_captured_next;

    // The completeness check sees a capture landing on the same edge as fsm_done.
    assign w_error_set = (store_response_puf & (~w_in_collect | ~w_sel_in_range | w_duplicate))
                       | (w_in_collect & fsm_done & w_incomplete);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT:      if (fsm_done)                  w_state_next = S_COMPARE;
            S_COMPARE:      if (r_pair == c_last_pair)     w_state_next = S_OUTPUT;
            S_OUTPUT:       if (r_valid && response_ready) w_state_next = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (!fsm_done)                 w_state_next = S_COLLECT;
            default:                                       w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LOOPS; i++) r_avg[i] <= '0;
        end else if (w_store_ok) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                if (w_sel_onehot[i]) r_avg[i] <= w_avg_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_captured <= '0;
        end else if (r_state == S_WAIT_RELEASE && !fsm_done) begin
            r_captured <= '0;
        end else begin
            r_captured <= w_captured_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pair <= '0;
        end else if (r_state == S_COMPARE && r_pair != c_last_pair) begin
            r_pair <= r_pair + c_pair_bits'(1);
        end else begin
            r_pair <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_response <= '0;
        end else if (r_state == S_COMPARE) begin
            for (int j = 0; j < RESPONSE_BITS; j++) begin
                if (r_pair == c_pair_bits'(j)) r_response[j] <= w_pair_gt[j];
            end
        end
    end

    // Valid rises one cycle after entering OUTPUT, once every pair bit has settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (r_state == S_OUTPUT) begin
            if (!r_valid) begin
                r_valid <= 1'b1;
            end else if (response_ready) begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_error_set) begin
            r_error <= 1'b1;
        end
    end

    assign response       = r_response;
    assign response_valid = r_valid;
    assign busy           = (r_state == S_COMPARE) || (r_state == S_OUTPUT);
    assign error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_response_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_builder
// Brief    : Self-checking bench for response_builder (NUM_LOOPS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_builder;

    localparam int NL = 4;
    localparam int SB = 3;

    logic        clk;
    logic        reset;
    logic        store_response_puf;
    logic [SB-1:0] select_puf;
    logic [31:0] counter_value;
    logic        fsm_done;
    logic [1:0]  response;
    logic        response_valid;
    logic        response_ready;
    logic        busy;
    logic        error;

    response_builder #(
        .NUM_LOOPS(NL), .SEL_BITS(SB), .COUNT_BITS(32),
        .AVG_SHIFT(12), .AVG_BITS(16), .RESPONSE_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .store_response_puf(store_response_puf),
        .select_puf(select_puf), .counter_value(counter_value), .fsm_done(fsm_done),
        .response(response), .response_valid(response_valid),
        .response_ready(response_ready), .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: averages per loop, which loops were stored, sticky error.
    logic [15:0]   m_avg [NL];
    logic [NL-1:0] m_cap;
    logic          m_err;

    typedef struct packed {
        logic [3:0][31:0] cnt;
        logic [7:0]       delay;
        logic [1:0]       exp_resp;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] avg_of(input logic [31:0] cnt);
        longint q;
        q = longint'(cnt) / 4096;
        return (q > 65535) ? 16'hFFFF : q[15:0];
    endfunction

    function automatic logic [1:0] model_resp();
        logic [1:0] r;
        for (int k = 0; k < 2; k++) r[k] = (m_avg[2*k] > m_avg[2*k+1]);
        return r;
    endfunction

    function automatic logic [31:0] rand_count();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom();
            1:       r = $urandom_range(0, 32'h000F_FFFF);
            2:       r = 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
            default: r = {4'h0, 28'($urandom())};
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_store(input int sel, input logic [31:0] cnt);
        if (sel >= NL) begin
            m_err = 1'b1;
        end else begin
            if (m_cap[sel]) m_err = 1'b1;
            m_avg[sel] = avg_of(cnt);
            m_cap[sel] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_avg[i] = 16'h0;
        m_cap = '0;
        m_err = 1'b0;
    endtask

    task automatic store(input int sel, input logic [31:0] cnt);
        store_response_puf = 1'b1;
        select_puf         = SB'(sel);
        counter_value      = cnt;
        model_store(sel, cnt);
        tick();
        store_response_puf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        store_response_puf = 1'b0;
        fsm_done = 1'b0;
        response_ready = 1'b0;
        select_puf = '0;
        counter_value = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!response_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Raises fsm_done (optionally together with a final store), checks latency,
    // the offered word under backpressure, the handshake and the release.
    task automatic run_challenge(input int last_sel, input logic [31:0] last_cnt,
                                 input int delay, input logic [1:0] exp_in,
                                 input bit use_model, input string tag);
        int lat;
        logic [1:0] exp_resp;
        response_ready = (delay == 0);
        fsm_done = 1'b1;
        if (last_sel >= 0) begin
            store_response_puf = 1'b1;
            select_puf         = SB'(last_sel);
            counter_value      = last_cnt;
            model_store(last_sel, last_cnt);
        end
        if (!(&m_cap)) m_err = 1'b1;
        exp_resp = use_model ? model_resp() : exp_in;
        tick();
        store_response_puf = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_resp"}, response, exp_resp);
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_hold_valid"}, response_valid, 1);
            check({tag, "_hold_resp"}, response, exp_resp);
        end
        response_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, response_valid, 0);
        check({tag, "_error"}, error, m_err);
        response_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, "_wait_idle"}, {response_valid, busy}, 2'b00);
        end
        fsm_done = 1'b0;
        tick();
        m_cap = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] c [4];
        int ord [4];
        int tmp;
        int sw;
        bit merge;

        vecs[0] = {32'h7000, 32'h2000, 32'h3000, 32'h5000, 8'd0, 2'b01};
        vecs[1] = {32'h1000_0000, 32'hFFFF_FFFF, 32'h4000, 32'h4000, 8'd0, 2'b00};
        vecs[2] = {32'h7000, 32'h2000, 32'h3000, 32'h5000, 8'd10, 2'b01};
        vecs[3] = {32'h1000, 32'h9000, 32'h9000, 32'h1000, 8'd2, 2'b10};

        // Reset values observed while reset is still asserted.
        reset = 1'b0;
        store_response_puf = 1'b0;
        fsm_done = 1'b0;
        response_ready = 1'b0;
        select_puf = '0;
        counter_value = '0;
        #3;
        check("rst_response", response, 0);
        check("rst_valid", response_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        do_reset();

        // Directed table: basic, tie/saturation, backpressure, re-run.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NL; i++) store(i, vecs[v].cnt[i]);
            run_challenge(-1, 32'h0, int'(vecs[v].delay), vecs[v].exp_resp, 1'b0,
                          $sformatf("vec%0d", v));
        end

        // Randomized challenges against the reference model.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NL; i++) c[i] = rand_count();
            if ($urandom_range(0, 2) == 0) c[1] = c[0];
            if ($urandom_range(0, 2) == 0) c[3] = c[2];
            for (int i = 0; i < NL; i++) ord[i] = i;
            for (int i = NL-1; i > 0; i--) begin
                sw = $urandom_range(0, i);
                tmp = ord[i];
                ord[i] = ord[sw];
                ord[sw] = tmp;
            end
            merge = 1'($urandom_range(0, 1));
            for (int j = 0; j < (merge ? 3 : 4); j++) store(ord[j], c[ord[j]]);
            run_challenge(merge ? ord[3] : -1, c[ord[3]], $urandom_range(0, 4),
                          2'b00, 1'b1, "rand");
        end

        // (a) duplicate store: error raised, second value kept.
        do_reset();
        store(1, 32'h2000);
        check("dup_err_before", error, 0);
        store(1, 32'h9000);
        check("dup_err", error, 1);
        store(0, 32'h5000);
        store(2, 32'h3000);
        store(3, 32'h1000);
        run_challenge(-1, 32'h0, 0, 2'b10, 1'b0, "dup");

        // (c) store pulse during OUTPUT is ignored but flagged.
        do_reset();
        store(0, 32'h5000);
        store(1, 32'h3000);
        store(2, 32'h2000);
        store(3, 32'h7000);
        fsm_done = 1'b1;
        tick();
        wait_valid(lat);
        check("outstore_latency", lat, 3);
        check("outstore_err_before", error, 0);
        store_response_puf = 1'b1;
        select_puf = 3'd0;
        counter_value = 32'hF000_0000;
        m_err = 1'b1;
        tick();
        store_response_puf = 1'b0;
        check("outstore_err", error, 1);
        check("outstore_valid", response_valid, 1);
        check("outstore_resp", response, 2'b01);
        response_ready = 1'b1;
        tick();
        check("outstore_drop", response_valid, 0);
        response_ready = 1'b0;
        fsm_done = 1'b0;
        tick();
        m_cap = '0;
        store(1, 32'h6000);
        store(2, 32'h2000);
        store(3, 32'h7000);
        run_challenge(-1, 32'h0, 1, 2'b00, 1'b1, "outstore_next");

        // Async reset in COMPARE, then (b) an incomplete challenge afterwards.
        do_reset();
        store(7, 32'h1234);
        check("range_err", error, 1);
        store(0, 32'h5000);
        store(1, 32'h3000);
        store(2, 32'h2000);
        store(3, 32'h7000);
        fsm_done = 1'b1;
        tick();
        tick();
        check("cmp_busy", busy, 1);
        check("cmp_partial", response, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", response_valid, 0);
        check("areset_resp", response, 0);
        check("areset_err", error, 0);
        check("areset_busy", busy, 0);
        model_reset();
        tick();
        fsm_done = 1'b0;
        reset = 1'b1;
        tick();
        check("post_reset_idle", {response_valid, busy, error}, 3'b000);
        store(0, 32'h1000);
        store(1, 32'h2000);
        store(2, 32'h1000);
        run_challenge(-1, 32'h0, 0, 2'b10, 1'b0, "missing");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
